// File: rtl/adda_pkg.sv
// ---------------------------------------------------------------------------
// adda_pkg
// Shared definitions for the ADC/DAC sample path: default sample width, the
// offset-binary midscale code, an offset-binary <-> two's-complement helper
// used by the interpolator, and the FIFO operation encoding used by the
// sample FIFO controller.
// ---------------------------------------------------------------------------
package adda_pkg;

  localparam int ADDA_DATAWIDTH = 14;

  // Encoding of the accepted operations in one cycle, {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Offset-binary code for zero signal: only the MSB set.
  function automatic logic [31:0] midscale(input int width);
    midscale = 32'd1 << (width - 1);
  endfunction

  // Offset-binary and two's complement differ only in the MSB, so the same
  // inversion converts in either direction.
  function automatic logic [ADDA_DATAWIDTH-1:0] offsetToTwos(
    input logic [ADDA_DATAWIDTH-1:0] sample
  );
    offsetToTwos = {~sample[ADDA_DATAWIDTH-1], sample[ADDA_DATAWIDTH-2:0]};
  endfunction

endpackage

// File: rtl/adc_sample_fifo_mem.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo_mem
// Simple dual-port DEPTH x DATAWIDTH sample store: synchronous write port,
// asynchronous read port. Contents are not reset.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module adc_sample_fifo_mem #(
  parameter int DATAWIDTH  = 14,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATAWIDTH-1:0]  wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATAWIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATAWIDTH-1:0] memArray_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      memArray_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = memArray_q[raddr_i];

endmodule

// File: rtl/adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo
// First-word-fall-through sample FIFO between ADC capture and the
// interpolator. The head word is presented on dout before it is popped;
// dout reads midscale while empty. Provides registered full/empty/count,
// an above-half flag used as the interpolator enable, and sticky
// overflow/underflow error flags cleared only by rst.
//
// Build option:
//   ADC_SAMPLE_FIFO_HYST_EN  when defined, above_half sets at
//                            count >= DEPTH/2 and clears only at
//                            count <= DEPTH/4 (holds in between).
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   wr_en       in   write request
//   din         in   sample to write
//   full        out  count == DEPTH
//   rd_en       in   pop request
//   dout        out  head word, midscale when empty
//   empty       out  count == 0
//   above_half  out  fill-level flag
//   count       out  occupancy 0..DEPTH
//   overflow    out  sticky: write attempted while full
//   underflow   out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module adc_sample_fifo
  import adda_pkg::*;
#(
  parameter int DATAWIDTH  = ADDA_DATAWIDTH,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATAWIDTH-1:0]  din,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATAWIDTH-1:0]  dout,
  output logic                  empty,
  output logic                  above_half,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [31:0]           MidScaleWide = midscale(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0]  MidScale     = MidScaleWide[DATAWIDTH-1:0];

  localparam logic [ADDR_WIDTH:0]   CountZero    = '0;
  localparam logic [ADDR_WIDTH:0]   CountOne     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CountFull    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CountHalf    = {2'b01, {(ADDR_WIDTH-1){1'b0}}};
`ifdef ADC_SAMPLE_FIFO_HYST_EN
  localparam logic [ADDR_WIDTH:0]   CountQuarter = {3'b001, {(ADDR_WIDTH-2){1'b0}}};
`endif
  localparam logic [ADDR_WIDTH-1:0] PtrOne       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  aboveHalf_q, aboveHalf_d;
  logic                  overflow_q, underflow_q;

  logic                  wrAccept, rdAccept;
  logic                  memWe;
  logic [DATAWIDTH-1:0]  memRdata;
  fifo_op_e              fifoOp;

  // Acceptance uses the registered flags, so a write while full or a read
  // while empty is dropped; the other side of a simultaneous request still
  // proceeds.
  always_comb begin
    wrAccept    = wr_en && !full_q;
    rdAccept    = rd_en && !empty_q;
    fifoOp      = fifo_op_e'({wrAccept, rdAccept});

    wrPtr_d     = wrAccept ? (wrPtr_q + PtrOne) : wrPtr_q;
    rdPtr_d     = rdAccept ? (rdPtr_q + PtrOne) : rdPtr_q;

    count_d     = count_q;
    case (fifoOp)
      OP_WRITE: count_d = count_q + CountOne;
      OP_READ:  count_d = count_q - CountOne;
      default:  count_d = count_q;
    endcase

`ifdef ADC_SAMPLE_FIFO_HYST_EN
    aboveHalf_d = aboveHalf_q;
    if (count_d >= CountHalf) begin
      aboveHalf_d = 1'b1;
    end else if (count_d <= CountQuarter) begin
      aboveHalf_d = 1'b0;
    end
`else
    aboveHalf_d = (count_d >= CountHalf);
`endif
  end

  // Flags are registered from the next count so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= CountZero;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      aboveHalf_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CountFull);
      empty_q     <= (count_d == CountZero);
      aboveHalf_q <= aboveHalf_d;
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // A write presented during the reset cycle must not land in memory.
  assign memWe = wrAccept && !rst;

  adc_sample_fifo_mem #(
    .DATAWIDTH (DATAWIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (memWe),
    .waddr_i(wrPtr_q),
    .wdata_i(din),
    .raddr_i(rdPtr_q),
    .rdata_o(memRdata)
  );

  assign dout       = empty_q ? MidScale : memRdata;
  assign full       = full_q;
  assign empty      = empty_q;
  assign above_half = aboveHalf_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_fifo
// Self-checking bench for adc_sample_fifo. A queue holds the words the bench
// expects to be accepted; popped words are compared against dout at the
// moment rd_en is presented. A small occupancy model predicts the flags.
// Honours ADC_SAMPLE_FIFO_HYST_EN for the above_half expectation.
// ---------------------------------------------------------------------------
module tb_adc_sample_fifo;

  localparam int DW    = 14;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] MID = 14'h2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic          above_half;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int testsRun  = 0;
  int testsFail = 0;

  logic [DW-1:0] expQ [$];
  int   modelCount;
  logic modelAbove, modelOvf, modelUnf;

  always #5 clk = ~clk;

  adc_sample_fifo #(.DATAWIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .din       (din),
    .full      (full),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .above_half(above_half),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".count"}, 32'(count), 32'(modelCount));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(modelCount == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(modelCount == DEPTH));
    checkOutput({tag, ".above_half"}, 32'(above_half), 32'(modelAbove));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(modelOvf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(modelUnf));
    if (modelCount == 0) checkOutput({tag, ".dout_mid"}, 32'(dout), 32'(MID));
    else                 checkOutput({tag, ".dout_head"}, 32'(dout), 32'(expQ[0]));
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] d,
                               input logic r, input string tag);
    bit wAcc, rAcc;
    wr_en = w; din = d; rd_en = r;
    wAcc = w && (modelCount < DEPTH);
    rAcc = r && (modelCount > 0);
    if (w && modelCount == DEPTH) modelOvf = 1'b1;
    if (r && modelCount == 0)     modelUnf = 1'b1;
    if (rAcc) checkOutput({tag, ".pop"}, 32'(dout), 32'(expQ.pop_front()));
    if (wAcc) expQ.push_back(d);
    modelCount = modelCount + (wAcc ? 1 : 0) - (rAcc ? 1 : 0);
`ifdef ADC_SAMPLE_FIFO_HYST_EN
    if (modelCount >= DEPTH/2)      modelAbove = 1'b1;
    else if (modelCount <= DEPTH/4) modelAbove = 1'b0;
`else
    modelAbove = (modelCount >= DEPTH/2);
`endif
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    checkModel(tag);
  endtask

  // Reset with both requests active to show they are ignored.
  task automatic doReset(input string tag);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 14'h1555;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    expQ.delete();
    modelCount = 0; modelAbove = 1'b0; modelOvf = 1'b0; modelUnf = 1'b0;
    checkModel(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    modelCount = 0; modelAbove = 1'b0; modelOvf = 1'b0; modelUnf = 1'b0;
    @(posedge clk);
    #1;

    // 1. Reset then idle
    doReset("reset");
    checkOutput("reset.dout", 32'(dout), 32'h2000);
    applyStimulus(1'b0, '0, 1'b0, "idle");

    // 2. Fill to 64, then overflow attempt
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, "fill");
      if (i == 31) checkOutput("fill.ah_at31", 32'(above_half), 32'd0);
      if (i == 32) checkOutput("fill.ah_at32", 32'(above_half), 32'd1);
    end
    checkOutput("fill.full64", 32'(full), 32'd1);
    applyStimulus(1'b1, 14'h3FFF, 1'b0, "ovf");
    checkOutput("ovf.flag", 32'(overflow), 32'd1);
    checkOutput("ovf.count", 32'(count), 32'd64);

    // 3. FWFT ordering
    doReset("fwft.rst");
    applyStimulus(1'b1, 14'h1234, 1'b0, "fwft.w1");
    checkOutput("fwft.first", 32'(dout), 32'h1234);
    applyStimulus(1'b1, 14'h2ABC, 1'b0, "fwft.w2");
    applyStimulus(1'b0, '0, 1'b1, "fwft.r1");
    checkOutput("fwft.second", 32'(dout), 32'h2ABC);
    applyStimulus(1'b0, '0, 1'b1, "fwft.r2");
    checkOutput("fwft.empty", 32'(empty), 32'd1);
    checkOutput("fwft.mid", 32'(dout), 32'h2000);

    // 4a. Simultaneous read/write at count=10
    doReset("both.rst");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(14'h0100 + i), 1'b0, "both.pre");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(14'h0200 + i), 1'b1, "both.rw");
    checkOutput("both.count10", 32'(count), 32'd10);
    checkOutput("both.dout5", 32'(dout), 32'h0105);

    // 4b. Both at full
    doReset("bfull.rst");
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, DW'(14'h0800 + i), 1'b0, "bfull.fill");
    applyStimulus(1'b1, 14'h3AAA, 1'b1, "bfull.rw");
    checkOutput("bfull.count63", 32'(count), 32'd63);
    checkOutput("bfull.ovf", 32'(overflow), 32'd1);

    // 4c. Both at empty
    doReset("bempty.rst");
    applyStimulus(1'b1, 14'h0ABC, 1'b1, "bempty.rw");
    checkOutput("bempty.count1", 32'(count), 32'd1);
    checkOutput("bempty.unf", 32'(underflow), 32'd1);
    checkOutput("bempty.dout", 32'(dout), 32'h0ABC);

    // 5. Pointer wrap streaming 200 words
    doReset("wrap.rst");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'($urandom_range(0, 16383)), 1'b0, "wrap.pre");
    for (int i = 8; i < 200; i++) applyStimulus(1'b1, DW'($urandom_range(0, 16383)), 1'b1, "wrap.rw");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, "wrap.drain");
    checkOutput("wrap.empty", 32'(empty), 32'd1);
    checkOutput("wrap.noovf", 32'(overflow), 32'd0);
    checkOutput("wrap.nounf", 32'(underflow), 32'd0);

    // 6. above_half release point
    doReset("hyst.rst");
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, DW'(14'h1000 + i), 1'b0, "hyst.fill");
    checkOutput("hyst.set32", 32'(above_half), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, "hyst.drain");
`ifdef ADC_SAMPLE_FIFO_HYST_EN
    checkOutput("hyst.at31", 32'(above_half), 32'd1);
`else
    checkOutput("hyst.at31", 32'(above_half), 32'd0);
`endif
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b1, "hyst.drain");
`ifdef ADC_SAMPLE_FIFO_HYST_EN
    checkOutput("hyst.at17", 32'(above_half), 32'd1);
`else
    checkOutput("hyst.at17", 32'(above_half), 32'd0);
`endif
    applyStimulus(1'b0, '0, 1'b1, "hyst.drain");
    checkOutput("hyst.at16", 32'(above_half), 32'd0);
    checkOutput("hyst.count16", 32'(count), 32'd16);

    // Mid-stream reset
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(14'h2100 + i), 1'b0, "mid.fill");
    applyStimulus(1'b1, 14'h3FFF, 1'b1, "mid.rw");
    doReset("mid.rst");
    checkOutput("mid.dout", 32'(dout), 32'h2000);
    checkOutput("mid.count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
